// File: rtl/enc_pkg.sv
// Shared definitions for the RV32E instruction encoder.
//   - base opcode constants and the opcode -> format map
//   - error-cause codes, in priority order (lowest non-zero wins)
//   - NOP word stored in place of an illegal request
//   - enc_entry_t: one 35-bit FIFO entry {code, inst}; err is implied by code != 0
package enc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_OPCODE = 3'd1;
  localparam logic [2:0] ERR_REG    = 3'd2;
  localparam logic [2:0] ERR_IMM    = 3'd3;
  localparam logic [2:0] ERR_ALIGN  = 3'd4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] inst;
  } enc_entry_t;

  function automatic fmt_e op_fmt(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC:                     return FMT_U;
      OP_JAL:                               return FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:  return FMT_I;
      OP_BRANCH:                            return FMT_B;
      OP_STORE:                             return FMT_S;
      OP_REG:                               return FMT_R;
      default:                              return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/rv32e_inst_encoder_if.sv
// Request/response bundle between the sequencer (master) and the encoder (slave).
//   in_*  : field request, valid/ready handshake
//   out_* : encoded FIFO head, valid/ready handshake
interface rv32e_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [2:0]  out_err_code;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_err_code
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_err_code
  );
endinterface

// File: rtl/enc_fifo.sv
// DEPTH x W synchronous FIFO. Pointers carry one wrap bit beyond the index so
// full and empty are distinguishable without a separate count.
//   clk, rst_n       : clock, async active-low reset (empties the FIFO)
//   push_i, din_i    : write tail (caller must not push when full_o)
//   pop_i, dout_o    : read head (dout_o is the head register, valid when !empty_o)
//   full_o, empty_o  : occupancy flags
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/rv32e_inst_encoder.sv
// RV32E instruction encoder: packs opcode/funct/register/immediate fields into
// a 32-bit word, range-checks them, and queues {word, cause} in an output FIFO.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of rv32e_inst_encoder_if (request in, encoded word out)
//   inst_cnt   : accepted requests (legal or not), wrapping
module rv32e_inst_encoder
  import enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16,
  parameter int RVE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32e_inst_encoder_if.slave bus,
  output logic [CNT_W-1:0] inst_cnt
);

  function automatic logic reg_bad(input logic [4:0] r);
    return (RVE != 0) && r[4];
  endfunction

  function automatic enc_entry_t encode(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    enc_entry_t e;
    fmt_e       fmt;
    logic       shamt, bad_reg, bad_imm, bad_align;
    logic [31:0] w;
    fmt       = op_fmt(op);
    // slli/srli/srai: funct7 occupies the top bits, imm carries only the shamt
    shamt     = (op == OP_IMM) && (f3[1:0] == 2'b01);
    bad_reg   = 1'b0;
    bad_imm   = 1'b0;
    bad_align = 1'b0;
    w         = NOP_INST;
    case (fmt)
      FMT_R: begin
        bad_reg = reg_bad(rd) || reg_bad(rs1) || reg_bad(rs2);
        w = {f7, rs2, rs1, f3, rd, op};
      end
      FMT_I: begin
        bad_reg = reg_bad(rd) || reg_bad(rs1);
        if (shamt) begin
          bad_imm = |imm[31:5];
          w = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          bad_imm = !((&imm[31:11]) || !(|imm[31:11]));
          w = {imm[11:0], rs1, f3, rd, op};
        end
      end
      FMT_S: begin
        bad_reg = reg_bad(rs1) || reg_bad(rs2);
        bad_imm = !((&imm[31:11]) || !(|imm[31:11]));
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      FMT_B: begin
        bad_reg   = reg_bad(rs1) || reg_bad(rs2);
        bad_imm   = !((&imm[31:12]) || !(|imm[31:12]));
        bad_align = imm[0];
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      FMT_U: begin
        bad_reg   = reg_bad(rd);
        bad_align = |imm[11:0];
        w = {imm[31:12], rd, op};
      end
      FMT_J: begin
        bad_reg   = reg_bad(rd);
        bad_imm   = !((&imm[31:20]) || !(|imm[31:20]));
        bad_align = imm[0];
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: ;
    endcase
    if (fmt == FMT_BAD) e.code = ERR_OPCODE;
    else if (bad_reg)   e.code = ERR_REG;
    else if (bad_imm)   e.code = ERR_IMM;
    else if (bad_align) e.code = ERR_ALIGN;
    else                e.code = ERR_NONE;
    e.inst = (e.code == ERR_NONE) ? w : NOP_INST;
    return e;
  endfunction

  enc_entry_t       ent, head;
  logic             full, empty, push, pop;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ent = encode(bus.in_opcode, bus.in_funct3, bus.in_funct7,
                 bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
  end

  assign push = bus.in_valid && !full;
  assign pop  = !empty && bus.out_ready;

  enc_fifo #(.DEPTH(DEPTH), .W($bits(enc_entry_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cnt_d = push ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Head fields are forced to zero when empty so reset/idle outputs are clean.
  assign bus.in_ready     = !full;
  assign bus.out_valid    = !empty;
  assign bus.out_inst     = empty ? 32'h0 : head.inst;
  assign bus.out_err_code = empty ? 3'h0 : head.code;
  assign bus.out_err      = !empty && (head.code != ERR_NONE);
  assign inst_cnt         = cnt_q;

endmodule

// File: tb/tb_rv32e_inst_encoder.sv
module tb_rv32e_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] inst_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;

  rv32e_inst_encoder_if bus();

  rv32e_inst_encoder #(.DEPTH(2), .CNT_W(16), .RVE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .inst_cnt (inst_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'b0110111, JAL = 7'b1101111, IMM = 7'b0010011,
                         BR  = 7'b1100011, ST  = 7'b0100011, RR  = 7'b0110011,
                         FNC = 7'b0001111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.in_opcode = op;  bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rd = rd;      bus.in_rs1 = rs1;   bus.in_rs2 = rs2;
    bus.in_imm = imm;    bus.in_valid = 1'b1;
  endtask

  // One request with out_ready=1: visible the cycle after accept, popped the next.
  task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] exp_inst, input logic [2:0] exp_code);
    drive(op, f3, f7, rd, rs1, rs2, imm);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_cnt++;
    chk({tag, ".vld"},  32'(bus.out_valid), 32'd1);
    chk({tag, ".inst"}, bus.out_inst, exp_inst);
    chk({tag, ".err"},  32'(bus.out_err), 32'(exp_code != 3'd0));
    chk({tag, ".code"}, 32'(bus.out_err_code), 32'(exp_code));
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    #1;
    chk("rst.vld",   32'(bus.out_valid), 32'd0);
    chk("rst.inst",  bus.out_inst, 32'h0);
    chk("rst.err",   32'(bus.out_err), 32'd0);
    chk("rst.code",  32'(bus.out_err_code), 32'd0);
    chk("rst.cnt",   32'(inst_cnt), 32'd0);
    chk("rst.ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    vec("addi",   IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0050_0093, 3'd0);
    chk("cnt1", 32'(inst_cnt), 32'(exp_cnt));
    vec("lui",    LUI, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 3'd0);
    vec("jal",    JAL, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 3'd0);
    vec("sw",     ST,  3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_A423, 3'd0);
    vec("add",    RR,  3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h0020_81B3, 3'd0);
    vec("beqneg", BR,  3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 3'd0);
    vec("srai",   IMM, 3'b101, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3,        32'h4030_D093, 3'd0);
    vec("addimin",IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 3'd0);
    vec("beqodd", BR,  3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,        32'h0000_0013, 3'd4);
    vec("addix16",IMM, 3'b000, 7'h00, 5'd16,5'd0, 5'd0, 32'd5,        32'h0000_0013, 3'd2);
    vec("slli32", IMM, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd32,       32'h0000_0013, 3'd3);
    vec("fence",  FNC, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0,        32'h0000_0013, 3'd1);
    vec("addi2k", IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0000_0013, 3'd3);
    vec("luilow", LUI, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0000_1001, 32'h0000_0013, 3'd4);
    vec("jalbig", JAL, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h0000_0013, 3'd3);
    vec("prio",   IMM, 3'b000, 7'h00, 5'd16,5'd0, 5'd0, 32'd5000,     32'h0000_0013, 3'd2);
    chk("cntv", 32'(inst_cnt), 32'(exp_cnt));

    // Backpressure: A, B fill DEPTH=2; C is held until the first pop.
    bus.out_ready = 1'b0;
    drive(IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    @(posedge clk); #1;
    chk("bp.rdyA", 32'(bus.in_ready), 32'd1);
    drive(IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2);
    @(posedge clk); #1;
    chk("bp.full", 32'(bus.in_ready), 32'd0);
    drive(IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
    @(posedge clk); #1;
    exp_cnt += 2;
    chk("bp.hold",  32'(bus.in_ready), 32'd0);
    chk("bp.stabA", bus.out_inst, 32'h0010_0093);
    chk("bp.cnt2",  32'(inst_cnt), 32'(exp_cnt));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.headB", bus.out_inst, 32'h0020_0093);
    chk("bp.noC",   32'(inst_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_cnt++;
    chk("bp.headC", bus.out_inst, 32'h0030_0093);
    chk("bp.cnt3",  32'(inst_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    chk("bp.empty", 32'(bus.out_valid), 32'd0);

    // Simultaneous push/pop at occupancy 1.
    bus.out_ready = 1'b0;
    drive(IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd100);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'(100 + i));
      @(posedge clk); #1;
      chk("pp.rdy",  32'(bus.in_ready), 32'd1);
      chk("pp.vld",  32'(bus.out_valid), 32'd1);
      chk("pp.inst", bus.out_inst, (32'(100 + i) << 20) | 32'h93);
    end
    bus.in_valid = 1'b0;
    exp_cnt += 11;
    @(posedge clk); #1;
    chk("pp.drain", 32'(bus.out_valid), 32'd0);
    chk("pp.cnt",   32'(inst_cnt), 32'(exp_cnt));

    // Asynchronous reset with two entries buffered.
    bus.out_ready = 1'b0;
    drive(IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd7);
    @(posedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("ar.full", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.vld",   32'(bus.out_valid), 32'd0);
    chk("ar.cnt",   32'(inst_cnt), 32'd0);
    chk("ar.rdy",   32'(bus.in_ready), 32'd1);
    chk("ar.inst",  bus.out_inst, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    vec("post", IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 3'd0);
    chk("post.cnt", 32'(inst_cnt), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
